// File: rtl/rf_sequencer_if.sv
// rf_sequencer_if: instruction handshake plus register-file / ALU control bundle
// of the rf_sequencer. The slave modport is the sequencer's view; the master
// modport is the instruction-source / datapath view.
`timescale 1ns/1ps

interface rf_sequencer_if;
  logic       IValid;
  logic [9:0] Instr;
  logic       IReady;
  logic       ENW;
  logic [1:0] WRA;
  logic       ENR0;
  logic [1:0] RDA0;
  logic       ENR1;
  logic [1:0] RDA1;
  logic       Extrn;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [2:0] FN;
  logic       Done;
  logic       Err;

  modport slave (
    input  IValid, Instr,
    output IReady, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
    output Extrn, Ain, Gin, Gout, FN, Done, Err
  );

  modport master (
    output IValid, Instr,
    input  IReady, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
    input  Extrn, Ain, Gin, Gout, FN, Done, Err
  );
endinterface

// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle control unit for the 10-bit processor's four-entry
// register file. Accepts one instruction per IValid/IReady handshake and steps
// IDLE -> T1 [-> T2 -> T3] emitting register-file enables/addresses and ALU
// strobes. All outputs are registered and Moore-decoded from (state, IR).
//
// Optional feature: define RFSEQ_BYPASS_EN to also raise IReady in every
// cycle that carries Done, so a new instruction can enter T1 directly.
`timescale 1ns/1ps

module rf_sequencer (
  input  logic           CLKb,
  input  logic           Rstb,
  rf_sequencer_if.slave  rf
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_e;

  // Registered control outputs, decoded one cycle ahead from next state/IR.
  typedef struct packed {
    logic       ready;
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic       extrn;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [2:0] fn;
    logic       done;
    logic       err;
  } ctl_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0111;

  // Idle outputs: only IReady high, every address zero.
  localparam ctl_t CTL_RESET = '{ready: 1'b1, default: '0};

  // IR holds {opcode[3:0], Rx[1:0], Ry[1:0]}; Instr[1:0] is never used.
  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  ctl_t       ctl_q, ctl_d;
  logic       xfer;
  logic       unused_instr_lsb;

  assign unused_instr_lsb = ^rf.Instr[1:0];

  // Handshake uses the registered IReady, so it is a pure function of state.
  assign xfer = rf.IValid & ctl_q.ready;

  function automatic logic is_alu(input logic [3:0] op);
    return !op[3] && (op[2:0] >= 3'd2);
  endfunction

  // Next-state and IR capture. Without bypass, IReady is low outside IDLE,
  // so the xfer terms in T1/T3 can only fire when bypass raises IReady.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = T1;
          ir_d    = rf.Instr[9:2];
        end
      end
      T1: begin
        if (is_alu(ir_q[7:4])) begin
          state_d = T2;
        end else if (xfer) begin
          state_d = T1;
          ir_d    = rf.Instr[9:2];
        end else begin
          state_d = IDLE;
        end
      end
      T2: state_d = T3;
      T3: begin
        if (xfer) begin
          state_d = T1;
          ir_d    = rf.Instr[9:2];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode for the state/IR that become current at the next edge.
  always_comb begin
    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    op    = ir_d[7:4];
    rx    = ir_d[3:2];
    ry    = ir_d[1:0];
    ctl_d = '0;
    unique case (state_d)
      IDLE: ;
      T1: begin
        if (op == OP_LOAD) begin
          ctl_d.extrn = 1'b1;
          ctl_d.enw   = 1'b1;
          ctl_d.wra   = rx;
          ctl_d.done  = 1'b1;
        end else if (op == OP_MOV) begin
          ctl_d.enr0  = 1'b1;
          ctl_d.rda0  = ry;
          ctl_d.enw   = 1'b1;
          ctl_d.wra   = rx;
          ctl_d.done  = 1'b1;
        end else if (is_alu(op)) begin
          ctl_d.enr0  = 1'b1;
          ctl_d.rda0  = rx;
          ctl_d.ain   = 1'b1;
        end else begin
          ctl_d.err   = 1'b1;
          ctl_d.done  = 1'b1;
        end
      end
      T2: begin
        ctl_d.gin = 1'b1;
        ctl_d.fn  = op[2:0];
        // NOT is unary: the second read port stays idle.
        if (op != OP_NOT) begin
          ctl_d.enr1 = 1'b1;
          ctl_d.rda1 = ry;
        end
      end
      T3: begin
        ctl_d.gout = 1'b1;
        ctl_d.enw  = 1'b1;
        ctl_d.wra  = rx;
        ctl_d.done = 1'b1;
      end
      default: ;
    endcase
`ifdef RFSEQ_BYPASS_EN
    ctl_d.ready = (state_d == IDLE) | ctl_d.done;
`else
    ctl_d.ready = (state_d == IDLE);
`endif
  end

  // State, IR and output registers with synchronous active-low reset.
  always_ff @(posedge CLKb) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!Rstb) begin
      state_q <= IDLE;
      ir_q    <= '0;
      ctl_q   <= CTL_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

  assign rf.IReady = ctl_q.ready;
  assign rf.ENW    = ctl_q.enw;
  assign rf.WRA    = ctl_q.wra;
  assign rf.ENR0   = ctl_q.enr0;
  assign rf.RDA0   = ctl_q.rda0;
  assign rf.ENR1   = ctl_q.enr1;
  assign rf.RDA1   = ctl_q.rda1;
  assign rf.Extrn  = ctl_q.extrn;
  assign rf.Ain    = ctl_q.ain;
  assign rf.Gin    = ctl_q.gin;
  assign rf.Gout   = ctl_q.gout;
  assign rf.FN     = ctl_q.fn;
  assign rf.Done   = ctl_q.done;
  assign rf.Err    = ctl_q.err;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed bench for rf_sequencer. Each cycle's full output
// bundle is compared against a hand-written expected vector. Expectations for
// Done cycles follow RFSEQ_BYPASS_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_rf_sequencer;

`ifdef RFSEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLKb = 1'b0;
  logic Rstb;
  int   checks = 0;
  int   errors = 0;

  rf_sequencer_if rf ();

  rf_sequencer dut (
    .CLKb (CLKb),
    .Rstb (Rstb),
    .rf   (rf)
  );

  always #5 CLKb = ~CLKb;

  // Field order: rdy enw wra enr0 rda0 enr1 rda1 extrn ain gin gout fn done err
  logic [18:0] obs;
  assign obs = {rf.IReady, rf.ENW, rf.WRA, rf.ENR0, rf.RDA0, rf.ENR1, rf.RDA1,
                rf.Extrn, rf.Ain, rf.Gin, rf.Gout, rf.FN, rf.Done, rf.Err};

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic rdy, input logic enw, input logic [1:0] wra,
                       input logic enr0, input logic [1:0] rda0,
                       input logic enr1, input logic [1:0] rda1,
                       input logic extrn, input logic ain, input logic gin,
                       input logic gout, input logic [2:0] fn,
                       input logic done, input logic err);
    logic [18:0] exp_v;
    exp_v = {rdy, enw, wra, enr0, rda0, enr1, rda1, extrn, ain, gin, gout,
             fn, done, err};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    Rstb      = 1'b0;
    rf.IValid = 1'b0;
    rf.Instr  = '0;

    // Reset held for two edges.
    tick();
    tick();
    check_idle("reset");

    // LOAD R2.
    Rstb      = 1'b1;
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0000_10_00_00;
    tick();
    rf.IValid = 1'b0;
    check("load_t1", BYP, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    check_idle("load_idle");

    // ADD R3,R1; IValid held with junk while busy must be ignored.
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0010_11_01_00;
    tick();
    rf.Instr  = 10'b1111_00_00_00;
    check("add_t1", 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0,
          1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    rf.IValid = 1'b0;
    check("add_t2", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1,
          1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    tick();
    check("add_t3", BYP, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    check_idle("add_idle");

    // NOT R2 (Ry field 3 must not reach RDA1).
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0111_10_11_00;
    tick();
    rf.IValid = 1'b0;
    check("not_t1", 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0,
          1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("not_t2", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
    tick();
    check("not_t3", BYP, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    check_idle("not_idle");

    // MOV R1,R1 still writes.
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0001_01_01_00;
    tick();
    rf.IValid = 1'b0;
    check("mov_t1", BYP, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    check_idle("mov_idle");

    // Illegal opcode 1010: one Err/Done cycle, no write.
    rf.IValid = 1'b1;
    rf.Instr  = 10'b1010_01_10_00;
    tick();
    rf.IValid = 1'b0;
    check("ill_t1", BYP, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    check_idle("ill_idle");

    // SUB R2,R1 reset during T2: no write ever issued.
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0011_10_01_00;
    tick();
    rf.IValid = 1'b0;
    check("sub_t1", 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0,
          1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    check("sub_t2", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1,
          1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
    Rstb = 1'b0;
    tick();
    check_idle("sub_reset");
    Rstb = 1'b1;
    tick();
    check_idle("sub_after_reset");

    // Back-to-back MOV R2,R0 / MOV R3,R2 / LOAD R1 with IValid held high.
    rf.IValid = 1'b1;
    rf.Instr  = 10'b0001_10_00_00;
    tick();
    rf.Instr  = 10'b0001_11_10_00;
    check("b2b_mov_a", BYP, 1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
`ifdef RFSEQ_BYPASS_EN
    tick();
    rf.Instr = 10'b0000_01_00_00;
    check("b2b_mov_b", 1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    rf.IValid = 1'b0;
    check("b2b_load", 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
`else
    tick();
    check_idle("b2b_gap_a");
    tick();
    rf.Instr = 10'b0000_01_00_00;
    check("b2b_mov_b", 1'b0, 1'b1, 2'd3, 1'b1, 2'd2, 1'b0, 2'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    check_idle("b2b_gap_b");
    tick();
    rf.IValid = 1'b0;
    check("b2b_load", 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
`endif
    tick();
    check_idle("b2b_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Multi-cycle control unit for the 10-bit processor's four-entry register file. It accepts one 10-bit instruction per valid/ready handshake and decodes it into per-cycle register-file enables and addresses (ENW/WRA, ENR0/RDA0, ENR1/RDA1) plus ALU strobes. It sits between the instruction source and the register file / ALU datapath. It is the only block that drives those register-file control inputs.

## Interface
- No parameters; data width fixed at 10 bits, register count fixed at 4.
- CLKb  input  1  clock; all state updates on rising edge
- Rstb  input  1  reset, synchronous, active-low
- IValid  input  1  instruction present on Instr
- Instr  input  10  instruction: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored
- IReady  output  1  sequencer can accept an instruction this cycle
- ENW  output  1  register-file write enable
- WRA  output  2  register-file write address
- ENR0, ENR1  output  1 each  read-port enables
- RDA0, RDA1  output  2 each  read-port addresses
- Extrn  output  1  external data drives datapath bus (LOAD)
- Ain  output  1  ALU operand latch strobe
- Gin  output  1  ALU result latch strobe
- Gout  output  1  ALU result drives write-back bus
- FN  output  3  ALU function code
- Done  output  1  one-cycle pulse in the final cycle of an instruction
- Err  output  1  one-cycle pulse on an illegal opcode

## Operation
- Opcodes:
  - 0000 LOAD Rx ← external data
  - 0001 MOV Rx ← Ry
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR: Rx ← Rx op Ry
  - 0111 NOT: Rx ← ~Rx
  - 1xxx illegal
- Handshake: transfer occurs when IValid & IReady at a rising edge. Instr is captured into an internal IR and held until Done.
- States: IDLE, T1, T2, T3.
- Transitions:
  - IDLE → T1 on transfer.
  - LOAD, MOV, illegal: T1 → IDLE.
  - ALU ops: T1 → T2 → T3 → IDLE.
- Outputs are Moore-decoded from state and IR. Every signal not listed for a state is 0.
  - IDLE: IReady=1.
  - T1 LOAD: Extrn=1, ENW=1, WRA=Rx, Done=1.
  - T1 MOV: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1.
  - T1 ALU: ENR0=1, RDA0=Rx, Ain=1.
  - T2 ALU: ENR1=1, RDA1=Ry, Gin=1, FN=opcode[2:0]. For NOT, ENR1=0 and RDA1=0.
  - T3 ALU: Gout=1, ENW=1, WRA=Rx, Done=1.
  - T1 illegal: Err=1, Done=1, ENW=0.
- Rx==Ry is legal for every opcode. MOV R1,R1 still asserts ENW.
- ENR0 and ENR1 are never asserted in the same cycle. ENW is asserted at most once per instruction.

## Timing
- Reset: Rstb low at a rising edge forces IDLE and IR=0. This holds in any state, including mid-instruction.
- First cycle after reset: IReady=1; all other outputs 0, addresses 0.
- A write in progress during the reset cycle is not cancelled, because outputs reflect state until that edge.
- Latency from transfer edge to Done:
  - 1 cycle for LOAD, MOV and illegal opcodes.
  - 3 cycles for ALU ops.
- Throughput (without bypass): one idle cycle between instructions. LOAD/MOV issue every 2 cycles; ALU ops every 4 cycles.
- IValid held with IReady=0 has no effect; Instr may change freely while IReady=0.

## Configuration
- RFSEQ_BYPASS_EN defined:
  - IReady is also 1 in any state where Done=1.
  - A transfer in that cycle goes directly to T1 with the new IR, skipping IDLE.
  - Back-to-back LOAD/MOV issue every cycle; ALU ops issue every 3 cycles.
  - Err behaves identically.
- RFSEQ_BYPASS_EN undefined: IReady=1 only in IDLE, as described above.

## Test plan
- Reset: hold Rstb=0 for 2 cycles, release -> IReady=1, ENW=ENR0=ENR1=0, WRA=RDA0=RDA1=0, Done=Err=0.
- LOAD: Instr=10'b0000_10_00_00 accepted -> next cycle Extrn=1, ENW=1, WRA=2, Done=1; following cycle IDLE with IReady=1.
- ADD R3,R1 (Instr=10'b0010_11_01_00) -> T1: ENR0=1, RDA0=3, Ain=1; T2: ENR1=1, RDA1=1, Gin=1, FN=3'b010; T3: Gout=1, ENW=1, WRA=3, Done=1.
- Illegal opcode 1010 -> exactly one cycle with Err=1, Done=1, ENW=0; returns to IDLE.
- Reset mid-ALU: assert Rstb=0 during T2 of SUB -> next cycle IDLE, no ENW pulse ever issued for that instruction.
- Bypass (RFSEQ_BYPASS_EN): IValid held high with MOV, MOV, LOAD -> Done high for 3 consecutive cycles, WRA follows each Rx; without the macro, Done pulses every other cycle.
